// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and default width.
package seq_mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one partial product per cycle, WIDTH steps per result.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module seq_multiplier
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_data,
   input  logic               mult_active,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               loading_done,
   output logic               mult_done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [2*WIDTH-1:0] acc, acc_next, result;
   logic [WIDTH-1:0]   mcand, mplier, a_cap, b_cap;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     sum;

   // Carry out of the upper half is kept and shifted down with everything else.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
      acc_next = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
   end

`ifdef SEQ_MULT_SIGNED_EN
   logic neg;
   // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
   assign a_cap  = multiplicand[WIDTH-1] ? (~multiplicand + 1'b1) : multiplicand;
   assign b_cap  = multiplier[WIDTH-1]   ? (~multiplier + 1'b1)   : multiplier;
   assign result = neg ? (~acc_next + 1'b1) : acc_next;
`else
   assign a_cap  = multiplicand;
   assign b_cap  = multiplier;
   assign result = acc_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         loading_done <= 1'b0;
         mult_done    <= 1'b0;
         product      <= '0;
         acc          <= '0;
         cnt          <= '0;
         mcand        <= '0;
         mplier       <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         neg          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_data) begin
                  mcand        <= a_cap;
                  mplier       <= b_cap;
                  acc          <= '0;
                  cnt          <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                  neg          <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
                  state        <= LOADED;
                  loading_done <= 1'b1;
                  mult_done    <= 1'b0;
               end
            end
            LOADED: begin
               if (mult_active) begin
                  state        <= RUN;
                  loading_done <= 1'b0;
               end else if (!load_data) begin
                  state        <= IDLE;
                  loading_done <= 1'b0;
               end
            end
            RUN: begin
               // load_data is deliberately not looked at here.
               if (!mult_active) begin
                  state <= IDLE;
               end else begin
                  acc    <= acc_next;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     product   <= result;
                     state     <= DONE;
                     mult_done <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=8); signed vectors run when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_data;
   logic        mult_active;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        loading_done;
   logic        mult_done;
   logic [15:0] product;

   int n_chk  = 0;
   int n_pass = 0;
   logic [15:0] last_prod;

   seq_multiplier #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_data    (load_data),
      .mult_active  (mult_active),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .loading_done (loading_done),
      .mult_done    (mult_done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Load, start, and run one multiplication, checking every cycle of the timeline.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input bit scramble);
      @(negedge clk);
      multiplicand = a; multiplier = b; load_data = 1'b1; mult_active = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_ld_done"}, {31'd0, loading_done}, 32'd1);
      chk({tag, "_md_clr"}, {31'd0, mult_done}, 32'd0);
      chk({tag, "_prod_hold_ld"}, {16'd0, product}, {16'd0, last_prod});
      @(negedge clk);
      load_data = 1'b0; mult_active = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_ld_drop"}, {31'd0, loading_done}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (scramble) begin
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            load_data    = (i == 3);
         end
         @(posedge clk); #1;
         if (i < 8) begin
            chk($sformatf("%s_md_early%0d", tag, i), {31'd0, mult_done}, 32'd0);
            chk($sformatf("%s_prod_hold%0d", tag, i), {16'd0, product}, {16'd0, last_prod});
         end else begin
            chk({tag, "_md_set"}, {31'd0, mult_done}, 32'd1);
            chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
         end
      end
      @(negedge clk);
      mult_active = 1'b0; load_data = 1'b0;
      last_prod = exp;
      @(posedge clk); #1;
      chk({tag, "_md_hold"}, {31'd0, mult_done}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; load_data = 1'b0; mult_active = 1'b0;
      multiplicand = '0; multiplier = '0;
      last_prod = '0;
      #3;
      chk("rst_ld", {31'd0, loading_done}, 32'd0);
      chk("rst_md", {31'd0, mult_done}, 32'd0);
      chk("rst_prod", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("u13x11", 8'd13, 8'd11, 16'h008F, 1'b0);
      run_op("restart2x3", 8'd2, 8'd3, 16'd6, 1'b0);

      // Abort after 4 RUN cycles
      @(negedge clk);
      multiplicand = 8'd200; multiplier = 8'd200; load_data = 1'b1;
      @(posedge clk); #1;
      chk("abort_ld", {31'd0, loading_done}, 32'd1);
      @(negedge clk);
      load_data = 1'b0; mult_active = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      mult_active = 1'b0;
      @(posedge clk); #1;
      chk("abort_md", {31'd0, mult_done}, 32'd0);
      chk("abort_prod", {16'd0, product}, {16'd0, last_prod});
      @(negedge clk);
      mult_active = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_idle_md", {31'd0, mult_done}, 32'd0);
      chk("abort_idle_ld", {31'd0, loading_done}, 32'd0);
      chk("abort_idle_prod", {16'd0, product}, {16'd0, last_prod});
      @(negedge clk);
      mult_active = 1'b0;

      run_op("scr9x7", 8'd9, 8'd7, 16'd63, 1'b1);

      // LOADED holds while load_data stays high, returns to IDLE when both drop
      @(negedge clk);
      multiplicand = 8'd5; multiplier = 8'd5; load_data = 1'b1;
      @(posedge clk); #1;
      chk("hold_ld1", {31'd0, loading_done}, 32'd1);
      @(posedge clk); #1;
      chk("hold_ld2", {31'd0, loading_done}, 32'd1);
      chk("hold_md", {31'd0, mult_done}, 32'd0);
      @(negedge clk);
      load_data = 1'b0;
      @(posedge clk); #1;
      chk("ret_idle_ld", {31'd0, loading_done}, 32'd0);
      @(negedge clk);
      mult_active = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("ret_idle_md", {31'd0, mult_done}, 32'd0);
      chk("ret_idle_prod", {16'd0, product}, {16'd0, last_prod});
      @(negedge clk);
      mult_active = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
      run_op("sm3x5", 8'hFD, 8'h05, 16'hFFF1, 1'b0);
      run_op("s80x80", 8'h80, 8'h80, 16'h4000, 1'b0);
      run_op("s7Fx80", 8'h7F, 8'h80, 16'hC080, 1'b0);
`else
      run_op("uFFxFF", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
      run_op("u0xA5", 8'h00, 8'hA5, 16'h0000, 1'b0);
`endif

      // Async reset in the middle of RUN, between edges
      @(negedge clk);
      multiplicand = 8'd100; multiplier = 8'd3; load_data = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_data = 1'b0; mult_active = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ld", {31'd0, loading_done}, 32'd0);
      chk("arst_md", {31'd0, mult_done}, 32'd0);
      chk("arst_prod", {16'd0, product}, 32'd0);
      mult_active = 1'b0;
      @(posedge clk); #1;
      chk("arst_hold_prod", {16'd0, product}, 32'd0);
      #1 rst = 1'b0;
      last_prod = '0;
      run_op("post_rst7x6", 8'd7, 8'd6, 16'd42, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (2..16).
REQ-002 SHALL have port: clk  input  1  system clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: load_data  input  1  level request from control unit to capture operands.
REQ-005 SHALL have port: mult_active  input  1  level from control unit; high while multiplication is permitted.
REQ-006 SHALL have port: multiplicand  input  WIDTH  operand A.
REQ-007 SHALL have port: multiplier  input  WIDTH  operand B.
REQ-008 SHALL have port: loading_done  output  1  operands captured; registered.
REQ-009 SHALL have port: mult_done  output  1  product valid; registered level.
REQ-010 SHALL have port: product  output  2*WIDTH  last completed result; registered.

Function
REQ-011 SHALL implement FSM states IDLE, LOADED, RUN, DONE.
REQ-012 IDLE or DONE with load_data=1 at an edge SHALL capture both operands, clear accumulator and step counter, and enter LOADED.
REQ-013 loading_done SHALL be 1 exactly while in LOADED, i.e. from the cycle after capture.
REQ-014 LOADED with mult_active=1 SHALL enter RUN; LOADED with load_data=0 and mult_active=0 SHALL return to IDLE.
REQ-015 RUN SHALL perform one shift-add step per cycle: if multiplier LSB=1, add multiplicand into accumulator upper half; shift accumulator/multiplier right one bit.
REQ-016 RUN SHALL complete after exactly WIDTH steps, write the result to product, and enter DONE on the same edge.
REQ-017 mult_done SHALL be 1 exactly while in DONE; the first mult_done cycle SHALL immediately follow the WIDTH-th RUN cycle.
REQ-018 Total latency SHALL be: load_data edge -> loading_done 1 cycle; first RUN edge -> mult_done WIDTH cycles.
REQ-019 mult_active=0 during RUN SHALL abort to IDLE on that edge; product SHALL keep its prior value; mult_done SHALL stay 0.
REQ-020 load_data during RUN SHALL be ignored.
REQ-021 load_data in DONE SHALL restart per REQ-012; mult_done SHALL drop on that edge; product SHALL hold the old value until the new completion.
REQ-022 Operands SHALL be sampled only on the REQ-012 edge; later input changes SHALL have no effect on the running operation.
REQ-023 product SHALL change only on a completion edge or reset.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, loading_done=0, mult_done=0, product=0, accumulator=0, counter=0, regardless of current state.
REQ-025 After rst deasserts, the block SHALL accept load_data on the first rising edge.

Configuration
REQ-026 With SEQ_MULT_SIGNED_EN defined, operands SHALL be two's complement: magnitudes captured at load (unsigned WIDTH-bit magnitude, so -2^(WIDTH-1) is legal), result negated at completion if operand signs differ.
REQ-027 Without SEQ_MULT_SIGNED_EN, operands and product SHALL be unsigned; latency SHALL be identical in both builds.

Structure
REQ-028 A shared package seq_mult_pkg SHALL hold the state type/encoding (IDLE=0, LOADED=1, RUN=2, DONE=3) and the default width constant.
REQ-029 The step counter SHALL be $clog2(WIDTH+1) bits; no sub-module is required; the FSM, counter and datapath SHALL live in one module.

Verification
REQ-030 Unsigned, WIDTH=8: A=13, B=11, load_data 1 cycle then mult_active -> loading_done 1 cycle after load, mult_done 8 cycles after first RUN edge, product=0x008F.
REQ-031 Signed build: A=-3 (0xFD), B=5 -> product=0xFFF1; A=0x80, B=0x80 -> product=0x4000; A=0x7F, B=0x80 -> product=0xC080.
REQ-032 Abort: 200*200 run, mult_active dropped after 4 RUN cycles -> IDLE next edge, mult_done=0, product unchanged from prior result.
REQ-033 Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately, state IDLE; a subsequent 7*6 run yields product=42.
REQ-034 Restart from DONE with product=143: load 2*3 -> mult_done drops on load edge, product stays 143 until completion, then 6.
REQ-035 Operand inputs changed every cycle during RUN -> product equals result of operands sampled at load edge.
